// File: rtl/bus_xfer_seq_if.sv
// Handshake and strobe bundle between the instruction-decode side and the bus transfer sequencer.
// master = request producer; slave = the sequencer itself.
interface bus_xfer_seq_if #(
    parameter int NUM_REGS = 8
);
    localparam int IDW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                req_valid;
    logic                req_ready;
    logic [IDW-1:0]      req_src;
    logic [IDW-1:0]      req_dst;
    logic [1:0]          req_cond;
    logic [15:0]         psw_in;
    logic                flush;
    logic [NUM_REGS-1:0] enable;
    logic [NUM_REGS-1:0] latch;
    logic                busy;
    logic                done;
    logic                skipped;

    modport master (
        output req_valid, req_src, req_dst, req_cond, psw_in, flush,
        input  req_ready, enable, latch, busy, done, skipped
    );

    modport slave (
        input  req_valid, req_src, req_dst, req_cond, psw_in, flush,
        output req_ready, enable, latch, busy, done, skipped
    );
endinterface

// File: rtl/bus_xfer_seq.sv
// Queued register-to-register transfer sequencer for the shared DATA bus: one-hot source
// drive (enable) and destination capture (latch) strobes, optionally gated on PSW flags.
module bus_xfer_seq #(
    parameter int NUM_REGS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    bus_xfer_seq_if.slave bus
);
    localparam int IDW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int EW  = 2 * IDW + 2;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    function automatic logic cond_met(input logic [1:0] cond, input logic [1:0] flags);
        logic met;
        case (cond)
            2'b00:   met = 1'b1;
            2'b01:   met = flags[0];
            2'b10:   met = flags[1];
            2'b11:   met = ~flags[0];
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDW-1:0] id);
        logic [NUM_REGS-1:0] vec;
        vec     = {NUM_REGS{1'b0}};
        vec[id] = 1'b1;
        return vec;
    endfunction

    state_t              state_r;
    logic [EW-1:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [PW:0]         count_r;
    logic [IDW-1:0]      cur_dst_r;
    logic [NUM_REGS-1:0] enable_r;
    logic [NUM_REGS-1:0] latch_r;
    logic                done_r;
    logic                skipped_r;

    logic [EW-1:0]       head_s;
    logic [IDW-1:0]      head_src_s;
    logic [IDW-1:0]      head_dst_s;
    logic [1:0]          head_cond_s;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic                go_s;

    // Head-of-queue decode and push/pop qualification; flush suppresses both
    always_comb begin
        head_s      = fifo_mem_r[rd_ptr_r];
        head_src_s  = head_s[EW-1 -: IDW];
        head_dst_s  = head_s[IDW+1 : 2];
        head_cond_s = head_s[1:0];
        full_s      = (count_r == DEPTH_C);
        empty_s     = (count_r == {(PW+1){1'b0}});
        push_s      = bus.req_valid && !full_s && !bus.flush;
        if ((state_r == ST_IDLE) && !empty_s && !bus.flush) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        go_s = cond_met(head_cond_s, bus.psw_in[1:0]) && (head_src_s != head_dst_s);
    end

    // Request queue: circular buffer with wrapping pointers and occupancy count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {EW{1'b0}};
            end
        end else if (bus.flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {bus.req_src, bus.req_dst, bus.req_cond};
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Transfer FSM: IDLE evaluates and pops the head, DRIVE settles the bus, LATCH captures
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            enable_r  <= {NUM_REGS{1'b0}};
            latch_r   <= {NUM_REGS{1'b0}};
            cur_dst_r <= {IDW{1'b0}};
            done_r    <= 1'b0;
            skipped_r <= 1'b0;
        end else if (bus.flush) begin
            state_r   <= ST_IDLE;
            enable_r  <= {NUM_REGS{1'b0}};
            latch_r   <= {NUM_REGS{1'b0}};
            done_r    <= 1'b0;
            skipped_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            skipped_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    latch_r <= {NUM_REGS{1'b0}};
                    if (pop_s && go_s) begin
                        state_r   <= ST_DRIVE;
                        enable_r  <= onehot(head_src_s);
                        cur_dst_r <= head_dst_s;
                    end else begin
                        state_r   <= ST_IDLE;
                        enable_r  <= {NUM_REGS{1'b0}};
                        skipped_r <= pop_s;
                    end
                end
                ST_DRIVE: begin
                    state_r <= ST_LATCH;
                    latch_r <= onehot(cur_dst_r);
                end
                ST_LATCH: begin
                    state_r  <= ST_IDLE;
                    enable_r <= {NUM_REGS{1'b0}};
                    latch_r  <= {NUM_REGS{1'b0}};
                    done_r   <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    enable_r <= {NUM_REGS{1'b0}};
                    latch_r  <= {NUM_REGS{1'b0}};
                end
            endcase
        end
    end

    assign bus.enable    = enable_r;
    assign bus.latch     = latch_r;
    assign bus.done      = done_r;
    assign bus.skipped   = skipped_r;
    assign bus.req_ready = !full_s;
    assign bus.busy      = (state_r != ST_IDLE) || !empty_s;
endmodule

// File: tb/tb_bus_xfer_seq.sv
// Self-checking bench for bus_xfer_seq: directed scenarios plus randomized traffic compared
// against a transfer-timeline model (queue of requests, each transfer scheduled as a 3-cycle event).
module tb_bus_xfer_seq;
    localparam int NUM_REGS   = 8;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_xfer_seq_if #(.NUM_REGS(NUM_REGS)) bus_if ();

    bus_xfer_seq #(.NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int mq_src[$];
    int mq_dst[$];
    int mq_cond[$];
    int edge_n    = 0;
    int pop_edge  = -100;
    int next_free = 0;
    int cur_src   = 0;
    int cur_dst   = 0;
    bit cur_go    = 1'b0;

    function automatic bit cond_true(input int c, input logic [15:0] p);
        case (c)
            0:       return 1'b1;
            1:       return p[0];
            2:       return p[1];
            default: return !p[0];
        endcase
    endfunction

    // {enable, latch, done, skipped, busy, req_ready}
    function automatic logic [19:0] obs_vec();
        return {bus_if.enable, bus_if.latch, bus_if.done, bus_if.skipped, bus_if.busy, bus_if.req_ready};
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [7:0] en;
        logic [7:0] la;
        logic       dn;
        logic       sk;
        logic       act;
        int         k;
        en = 8'h00; la = 8'h00; dn = 1'b0; sk = 1'b0; act = 1'b0;
        k = edge_n - pop_edge;
        if (cur_go && (k == 0 || k == 1)) begin
            en  = 8'h01 << cur_src;
            act = 1'b1;
        end
        if (cur_go && k == 1) la = 8'h01 << cur_dst;
        if (cur_go && k == 2) dn = 1'b1;
        if (!cur_go && k == 0) sk = 1'b1;
        return {en, la, dn, sk, act || (mq_src.size() > 0), mq_src.size() < FIFO_DEPTH};
    endfunction

    task automatic model_clear();
        mq_src.delete(); mq_dst.delete(); mq_cond.delete();
        pop_edge = -100;
        cur_go   = 1'b0;
    endtask

    task automatic drive(input bit v, input int s, input int d, input int c);
        bus_if.req_valid = v;
        bus_if.req_src   = 3'(s);
        bus_if.req_dst   = 3'(d);
        bus_if.req_cond  = 2'(c);
    endtask

    // advance the model by one edge using the inputs about to be sampled, then clock the DUT
    task automatic tick();
        int n;
        int c;
        bit acc;
        n = edge_n + 1;
        if (bus_if.flush) begin
            model_clear();
            next_free = n + 1;
        end else begin
            acc = bus_if.req_valid && (mq_src.size() < FIFO_DEPTH);
            if (n >= next_free && mq_src.size() > 0) begin
                cur_src   = mq_src.pop_front();
                cur_dst   = mq_dst.pop_front();
                c         = mq_cond.pop_front();
                cur_go    = cond_true(c, bus_if.psw_in) && (cur_src != cur_dst);
                pop_edge  = n;
                next_free = cur_go ? n + 3 : n + 1;
            end
            if (acc) begin
                mq_src.push_back(int'(bus_if.req_src));
                mq_dst.push_back(int'(bus_if.req_dst));
                mq_cond.push_back(int'(bus_if.req_cond));
            end
        end
        edge_n = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int other_reg(input int s);
        return (s + int'($urandom_range(1, 7))) % 8;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        bus_if.flush  = 1'b0;
        bus_if.psw_in = 16'h0000;
        drive(1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        total++;
        if (obs_vec() !== 20'h00001) begin
            bad++; $display("FAIL reset_state act=%h exp=%h", obs_vec(), 20'h00001);
        end
        reset = 1'b1;
        model_clear();
        next_free = edge_n + 1;
        tick();
        total++;
        if (obs_vec() !== 20'h00001) begin
            bad++; $display("FAIL reset_idle act=%h exp=%h", obs_vec(), 20'h00001);
        end
    endtask

    task automatic test_single();
        bus_if.psw_in = 16'h0000;
        drive(1'b1, 2, 5, 0);
        tick();
        drive(1'b0, 0, 0, 0);
        total++;
        if (bus_if.busy !== 1'b1 || bus_if.enable !== 8'h00) begin
            bad++; $display("FAIL single_accept busy=%b enable=%h exp busy=1 enable=00", bus_if.busy, bus_if.enable);
        end
        tick();
        total++;
        if ({bus_if.enable, bus_if.latch} !== 16'h0400) begin
            bad++; $display("FAIL single_drive act=%h exp=0400", {bus_if.enable, bus_if.latch});
        end
        tick();
        total++;
        if ({bus_if.enable, bus_if.latch} !== 16'h0420) begin
            bad++; $display("FAIL single_latch act=%h exp=0420", {bus_if.enable, bus_if.latch});
        end
        tick();
        total++;
        if ({bus_if.enable, bus_if.latch, bus_if.done, bus_if.busy} !== {16'h0000, 1'b1, 1'b0}) begin
            bad++; $display("FAIL single_done act=%h exp=%h", {bus_if.enable, bus_if.latch, bus_if.done, bus_if.busy}, {16'h0000, 1'b1, 1'b0});
        end
        tick();
        total++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
            bad++; $display("FAIL single_after done=%b busy=%b exp 0 0", bus_if.done, bus_if.busy);
        end
    endtask

    task automatic test_cond();
        logic [15:0] psw_t [4];
        int          cond_t [4];
        bit          go_t [4];
        psw_t  = '{16'h0001, 16'h0000, 16'h0002, 16'h0001};
        cond_t = '{1, 1, 2, 3};
        go_t   = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            int s;
            bit saw_latch;
            bit saw_skip;
            logic [19:0] obs;
            logic [19:0] exp;
            s = int'($urandom_range(0, 7));
            bus_if.psw_in = psw_t[i] | (16'($urandom) & 16'hFFFC);
            drive(1'b1, s, other_reg(s), cond_t[i]);
            tick();
            drive(1'b0, 0, 0, 0);
            saw_latch = 1'b0;
            saw_skip  = 1'b0;
            repeat (4) begin
                tick();
                obs = obs_vec(); exp = exp_vec(); total++;
                if (obs !== exp) begin
                    bad++; $display("FAIL cond_model edge=%0d act=%h exp=%h", edge_n, obs, exp);
                end
                if (bus_if.latch !== 8'h00) saw_latch = 1'b1;
                if (bus_if.skipped === 1'b1) saw_skip = 1'b1;
            end
            total++;
            if (saw_latch !== go_t[i] || saw_skip !== !go_t[i]) begin
                bad++; $display("FAIL cond_case%0d xfer=%b skip=%b exp xfer=%b skip=%b", i, saw_latch, saw_skip, go_t[i], !go_t[i]);
            end
        end
    endtask

    task automatic test_fifo_wrap();
        int rs [6];
        int rd [6];
        int idx;
        logic [15:0] got[$];
        logic [15:0] want[$];
        logic [7:0]  e_b;
        logic [7:0]  l_b;
        bit saw_full;
        bit saw_rise;
        logic [19:0] obs;
        logic [19:0] exp;
        bus_if.psw_in = 16'h0000;
        drive(1'b1, 0, 1, 0);
        want.push_back(16'h0102);
        for (int i = 0; i < 6; i++) begin
            rs[i] = int'($urandom_range(0, 7));
            rd[i] = other_reg(rs[i]);
            e_b = 8'h01 << rs[i];
            l_b = 8'h01 << rd[i];
            want.push_back({e_b, l_b});
        end
        tick();
        idx = 0; saw_full = 1'b0; saw_rise = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bit acc;
            if (idx < 6) drive(1'b1, rs[idx], rd[idx], 0);
            else drive(1'b0, 0, 0, 0);
            acc = (idx < 6) && (mq_src.size() < FIFO_DEPTH);
            tick();
            if (acc) idx++;
            obs = obs_vec(); exp = exp_vec(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL wrap_model edge=%0d act=%h exp=%h", edge_n, obs, exp);
            end
            if (bus_if.req_ready === 1'b0) saw_full = 1'b1;
            else if (saw_full) saw_rise = 1'b1;
            if (bus_if.latch !== 8'h00) got.push_back({bus_if.enable, bus_if.latch});
        end
        drive(1'b0, 0, 0, 0);
        total++;
        if (!(saw_full && saw_rise)) begin
            bad++; $display("FAIL wrap_ready full_seen=%b rise_seen=%b exp 1 1", saw_full, saw_rise);
        end
        total++;
        if (got.size() != want.size()) begin
            bad++; $display("FAIL wrap_count act=%0d exp=%0d", got.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                total++;
                if (got[i] !== want[i]) begin
                    bad++; $display("FAIL wrap_order idx=%0d act=%h exp=%h", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_src_eq_dst();
        int s;
        int latches;
        logic [19:0] obs;
        logic [19:0] exp;
        bus_if.psw_in = 16'h0000;
        drive(1'b1, 3, 3, 0);
        tick();
        s = int'($urandom_range(0, 7));
        drive(1'b1, s, other_reg(s), 0);
        tick();
        drive(1'b0, 0, 0, 0);
        total++;
        if ({bus_if.skipped, bus_if.enable, bus_if.latch} !== 17'h10000) begin
            bad++; $display("FAIL same_skip act=%h exp=10000", {bus_if.skipped, bus_if.enable, bus_if.latch});
        end
        latches = 0;
        repeat (5) begin
            tick();
            obs = obs_vec(); exp = exp_vec(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL same_model edge=%0d act=%h exp=%h", edge_n, obs, exp);
            end
            if (bus_if.latch !== 8'h00) latches++;
        end
        total++;
        if (latches != 1) begin
            bad++; $display("FAIL same_next latch_cycles=%0d exp=1", latches);
        end
    endtask

    task automatic test_flush();
        int guard;
        int s;
        bit saw_done;
        logic [19:0] obs;
        logic [19:0] exp;
        bus_if.psw_in = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            s = int'($urandom_range(0, 7));
            drive(1'b1, s, other_reg(s), 0);
            tick();
        end
        drive(1'b0, 0, 0, 0);
        guard = 0;
        while (!(cur_go && (edge_n - pop_edge == 1)) && guard < 10) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 10) begin
            bad++; $display("FAIL flush_reach cycles=%0d exp<10", guard);
        end
        total++;
        if (bus_if.latch === 8'h00) begin
            bad++; $display("FAIL flush_in_latch act=%h exp=nonzero", bus_if.latch);
        end
        bus_if.flush = 1'b1;
        s = int'($urandom_range(0, 7));
        drive(1'b1, s, other_reg(s), 0);
        tick();
        bus_if.flush = 1'b0;
        drive(1'b0, 0, 0, 0);
        total++;
        if (obs_vec() !== 20'h00001) begin
            bad++; $display("FAIL flush_clear act=%h exp=00001", obs_vec());
        end
        saw_done = 1'b0;
        repeat (4) begin
            tick();
            obs = obs_vec(); exp = exp_vec(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL flush_model edge=%0d act=%h exp=%h", edge_n, obs, exp);
            end
            if (bus_if.done === 1'b1 || bus_if.enable !== 8'h00) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++; $display("FAIL flush_stale act=1 exp=0");
        end
        s = int'($urandom_range(0, 7));
        drive(1'b1, s, other_reg(s), 0);
        tick();
        drive(1'b0, 0, 0, 0);
        saw_done = 1'b0;
        repeat (4) begin
            tick();
            obs = obs_vec(); exp = exp_vec(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL flush_after edge=%0d act=%h exp=%h", edge_n, obs, exp);
            end
            if (bus_if.done === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b1) begin
            bad++; $display("FAIL flush_resume done_seen=%b exp=1", saw_done);
        end
    endtask

    task automatic test_async_reset();
        int s;
        bit stale;
        logic [19:0] obs;
        logic [19:0] exp;
        bus_if.psw_in = 16'h0000;
        s = int'($urandom_range(0, 7));
        drive(1'b1, s, other_reg(s), 0);
        tick();
        s = int'($urandom_range(0, 7));
        drive(1'b1, s, other_reg(s), 0);
        tick();
        drive(1'b0, 0, 0, 0);
        total++;
        if (bus_if.enable === 8'h00) begin
            bad++; $display("FAIL areset_pre enable=%h exp=nonzero", bus_if.enable);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (obs_vec() !== 20'h00001) begin
            bad++; $display("FAIL areset_async act=%h exp=00001", obs_vec());
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_free = edge_n + 1;
        stale = 1'b0;
        repeat (6) begin
            tick();
            obs = obs_vec(); exp = exp_vec(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL areset_model edge=%0d act=%h exp=%h", edge_n, obs, exp);
            end
            if (bus_if.enable !== 8'h00 || bus_if.latch !== 8'h00 || bus_if.done !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale !== 1'b0) begin
            bad++; $display("FAIL areset_stale act=1 exp=0");
        end
    endtask

    task automatic test_random();
        logic [19:0] obs;
        logic [19:0] exp;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 99) < 60, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            bus_if.psw_in = 16'($urandom);
            bus_if.flush  = ($urandom_range(0, 29) == 0);
            tick();
            obs = obs_vec(); exp = exp_vec(); total++;
            if (obs !== exp) begin
                bad++; $display("FAIL random_model edge=%0d act=%h exp=%h", edge_n, obs, exp);
            end
        end
        bus_if.flush = 1'b0;
        drive(1'b0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_cond();
        test_fifo_wrap();
        test_src_eq_dst();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
